if_id_skid_reg: RTL and testbench

- IF/ID boundary register of the MIPS pipeline: captures fetched instruction word and PC, presents them to decode, and splits out the fields used directly downstream.
- 16-bit immediate and 6-bit opcode outputs feed the decode-stage 32-bit immediate extender.
- Valid/ready handshake on both sides with a 2-entry skid buffer gives full throughput under fetch/decode backpressure; synchronous flush supports branch/jump redirect.

---
 rtl/if_id_skid_reg.sv | 87 ++++++++
 tb/tb_if_id_skid_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID register with 2-entry skid buffer, flush and decoded instruction fields.
// Define IF_ID_PERF_EN to add the saturating stall_cnt output.
module if_id_skid_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_imm,
  output logic [25:0]        out_jtarget
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);
  logic               main_valid, skid_valid;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic               acc_in, acc_out;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || acc_out) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= acc_in;
        if (acc_in) begin
          main_instr <= in_instr;
          main_pc    <= in_pc;
        end
      end
    end else if (acc_in) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (main_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif

  assign out_instr   = main_instr;
  assign out_pc      = main_pc;
  assign out_opcode  = main_instr[31:26];
  assign out_rs      = main_instr[25:21];
  assign out_rt      = main_instr[20:16];
  assign out_rd      = main_instr[15:11];
  assign out_shamt   = main_instr[10:6];
  assign out_funct   = main_instr[5:0];
  assign out_imm     = main_instr[15:0];
  assign out_jtarget = main_instr[25:0];
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: random and directed checks of if_id_skid_reg against a 2-deep FIFO model.
module tb_if_id_skid_reg;
  localparam int PC_W = 32;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic in_ready, out_valid;
  logic [31:0] out_instr;
  logic [PC_W-1:0] out_pc;
  logic [5:0] out_opcode, out_funct;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_jtarget;
  int n_chk = 0, n_fail = 0;
  logic [PC_W+31:0] q[$];
  int stall_exp = 0;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cnt;
`endif

  if_id_skid_reg #(.PC_W(PC_W), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
    .out_imm(out_imm), .out_jtarget(out_jtarget)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [PC_W+31:0] e;
    logic [31:0] i;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      i = e[31:0];
      chk("out_instr", 64'(out_instr), 64'(i));
      chk("out_pc", 64'(out_pc), 64'(e[PC_W+31:32]));
      chk("out_opcode", 64'(out_opcode), 64'(i >> 26));
      chk("out_rs", 64'(out_rs), 64'((i >> 21) & 32'h1F));
      chk("out_rt", 64'(out_rt), 64'((i >> 16) & 32'h1F));
      chk("out_rd", 64'(out_rd), 64'((i >> 11) & 32'h1F));
      chk("out_shamt", 64'(out_shamt), 64'((i >> 6) & 32'h1F));
      chk("out_funct", 64'(out_funct), 64'(i & 32'h3F));
      chk("out_imm", 64'(out_imm), 64'(i & 32'hFFFF));
      chk("out_jtarget", 64'(out_jtarget), 64'(i & 32'h3FF_FFFF));
    end
`ifdef IF_ID_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
  endtask

  task automatic step();
    bit ai, ao;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      stall_exp = 0;
    end else begin
      if (q.size() > 0 && !out_ready && stall_exp < 16'hFFFF) stall_exp++;
      if (flush) q.delete();
      else begin
        ao = q.size() > 0 && out_ready;
        ai = in_valid && q.size() < 2;
        if (ao) void'(q.pop_front());
        if (ai) q.push_back({in_pc, in_instr});
      end
    end
    @(negedge clk);
    if (rst_n) compare();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
    in_valid = v;
    in_instr = ins;
    in_pc = in_pc + 32'd4;
    out_ready = r;
    flush = f;
  endtask

  logic [31:0] stream [3] = '{32'h3401FFFF, 32'h2002FFFF, 32'h3003FF00};
  logic [5:0] ops [3] = '{6'h0D, 6'h08, 6'h0C};
  logic [15:0] imms [3] = '{16'hFFFF, 16'hFFFF, 16'hFF00};

  initial begin
    step();
    rst_n = 1'b1;
    step();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_opcode", 64'(out_opcode), 64'd0);
    chk("rst out_imm", 64'(out_imm), 64'h0000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, stream[k], 1'b1, 1'b0);
      step();
      chk("stream instr", 64'(out_instr), 64'(stream[k]));
      chk("stream opcode", 64'(out_opcode), 64'(ops[k]));
      chk("stream imm", 64'(out_imm), 64'(imms[k]));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("drain out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h8C220004, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hAC230008, 1'b0, 1'b0);
    step();
    chk("skid in_ready", 64'(in_ready), 64'd0);
    chk("skid holds A", 64'(out_instr), 64'h8C220004);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("B after A", 64'(out_instr), 64'hAC230008);
    chk("in_ready back", 64'(in_ready), 64'd1);
    step();
    chk("AB drained", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h11111111, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22222222, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h33333333, 1'b0, 1'b1);
    step();
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("flushed word absent", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h44444444, 1'b0, 1'b0);
    step();
    step();
    chk("pre-reset skid full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
`ifdef IF_ID_PERF_EN
    drive(1'b1, 32'h55555555, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("stall_cnt 5", 64'(stall_cnt), 64'd5);
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    chk("stall_cnt after flush", 64'(stall_cnt), 64'd5);
`endif
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
